// File: rtl/fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared types for the FIFO push arbiter.
//   state_t : arbiter FSM state (IDLE = free arbitration, LOCKED = burst owner)
// -----------------------------------------------------------------------------
package fifo_ctrl_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage : fifo_ctrl_pkg

// File: rtl/fifo_push_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority search. It returns the first set bit of
// `valid`, searching upward from index `start` and wrapping modulo N.
// Ports:
//   valid [N]          : request vector
//   start [$clog2(N)]  : index with highest priority
//   found              : at least one request is set
//   idx   [$clog2(N)]  : index of the selected request (0 when none found)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        int            pos;
        logic [IW-1:0] pos_idx;
        // NOTE: every output gets a default first so no path through this block infers a latch.
        found   = 1'b0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        // Walk from the farthest offset down to offset 0 so the nearest valid
        // index (closest to start) is the last one written and therefore wins.
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(start) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IW'(pos);
            if (valid[pos_idx]) begin
                found = 1'b1;
                idx   = pos_idx;
            end
        end
    end

endmodule : rr_pick

// File: rtl/fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter
// Round-robin controller that shares one external `fifo` between N_REQ
// producers and exposes the FIFO read side as a valid/ready stream. The fifo
// has no overflow/underflow protection, so push/pop are issued only when the
// item count allows. A producer that wins may keep the FIFO for up to BURST
// consecutive beats (burst lock).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req_valid [N_REQ]    : producer i has data
//   req_data  [N_REQ*W]  : producer i data at [i*WIDTH +: WIDTH]
//   req_ready [N_REQ]    : one-hot/zero accept strobe
//   fifo_push_enable/data: to fifo push side
//   fifo_pop_enable      : to fifo pop side
//   fifo_pop_data        : from fifo head
//   fifo_item_count [CW] : from fifo occupancy
//   out_valid/data/ready : consumer stream
//   full, empty          : occupancy flags
//   lock_owner, locked   : burst lock status
// -----------------------------------------------------------------------------
module fifo_push_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 2,
    parameter  int BURST = 1,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   fifo_push_enable,
    output logic [WIDTH-1:0]       fifo_push_data,
    output logic                   fifo_pop_enable,
    input  logic [WIDTH-1:0]       fifo_pop_data,
    input  logic [CW-1:0]          fifo_item_count,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic                   full,
    output logic                   empty,
    output logic [IW-1:0]          lock_owner,
    output logic                   locked
);

    localparam int BW = $clog2(BURST + 1);

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] rr_ptr;
    logic [BW-1:0] beat_cnt;

    logic          owner_hold;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          winner_found;
    logic [IW-1:0] winner;
    logic [IW-1:0] rr_next;
    logic          push;

    // A locked owner keeps priority only while it still has data; dropping
    // req_valid releases the lock immediately and the cycle is arbitrated
    // normally from rr_ptr.
    assign owner_hold = (state == LOCKED) && req_valid[owner];

    rr_pick #(.N(N_REQ)) u_rr_pick (
        .valid (req_valid),
        .start (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign winner       = owner_hold ? owner : pick_idx;
    assign winner_found = owner_hold || pick_found;

    assign full  = (fifo_item_count == CW'(DEPTH));
    assign empty = (fifo_item_count == '0);

    // No push-through when full: a same-cycle pop does not free a slot for
    // the push, because the fifo's own count decides legality.
    assign push             = winner_found && !full && !rst;
    assign fifo_push_enable = push;
    assign fifo_push_data   = req_data[winner*WIDTH +: WIDTH];

    always_comb begin
        req_ready         = '0;
        req_ready[winner] = push;
    end

    assign out_valid       = !empty;
    assign out_data        = fifo_pop_data;
    assign fifo_pop_enable = out_valid && out_ready && !rst;

    assign locked     = (state == LOCKED) && !rst;
    assign lock_owner = locked ? owner : '0;

    assign rr_next = (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
        end else if (push) begin
            if (owner_hold) begin
                // Continuing burst: count the beat and release at BURST.
                if (beat_cnt + 1'b1 == BW'(BURST)) begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end else begin
                // Fresh grant: advance fairness pointer past the winner.
                rr_ptr <= rr_next;
                if (BURST == 1) begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end else begin
                    state    <= LOCKED;
                    owner    <= winner;
                    beat_cnt <= BW'(1);
                end
            end
        end else if ((state == LOCKED) && !req_valid[owner]) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end
        // LOCKED with owner valid but FIFO full: everything holds (stall).
    end

endmodule : fifo_push_arbiter

// File: tb/tb_fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_push_arbiter
// Three arbiter instances (BURST = 1, 2, 4), each beside a small behavioural
// depth-2 fifo. Directed stimulus queues the expected grants and popped words;
// a monitor on the falling edge pops and compares whenever a push or pop
// handshake is presented.
// -----------------------------------------------------------------------------
module tb_fifo_push_arbiter;

    localparam int NI = 3;

    typedef struct {
        int         inst;
        int         idx;
        logic [3:0] data;
    } grant_t;

    typedef struct {
        int         inst;
        logic [3:0] data;
    } beat_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid  [NI];
    logic [15:0] req_data   [NI];
    logic [3:0]  req_ready  [NI];
    logic        push_en    [NI];
    logic [3:0]  push_data  [NI];
    logic        pop_en     [NI];
    logic [3:0]  pop_data   [NI];
    logic [1:0]  item_count [NI];
    logic        out_valid  [NI];
    logic [3:0]  out_data   [NI];
    logic        out_ready  [NI];
    logic        full       [NI];
    logic        empty      [NI];
    logic [1:0]  lock_owner [NI];
    logic        locked     [NI];

    grant_t grant_q[$];
    beat_t  data_q[$];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int BL = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

        logic [3:0] mem [2];
        logic       wp;
        logic       rp;
        logic [1:0] cnt;

        fifo_push_arbiter #(
            .N_REQ (4),
            .WIDTH (4),
            .DEPTH (2),
            .BURST (BL)
        ) dut (
            .clk              (clk),
            .rst              (rst),
            .req_valid        (req_valid[g]),
            .req_data         (req_data[g]),
            .req_ready        (req_ready[g]),
            .fifo_push_enable (push_en[g]),
            .fifo_push_data   (push_data[g]),
            .fifo_pop_enable  (pop_en[g]),
            .fifo_pop_data    (pop_data[g]),
            .fifo_item_count  (item_count[g]),
            .out_valid        (out_valid[g]),
            .out_data         (out_data[g]),
            .out_ready        (out_ready[g]),
            .full             (full[g]),
            .empty            (empty[g]),
            .lock_owner       (lock_owner[g]),
            .locked           (locked[g])
        );

        // Behavioural depth-2 fifo, held in reset while rst is high.
        always @(posedge clk) begin
            if (rst) begin
                wp  <= 1'b0;
                rp  <= 1'b0;
                cnt <= 2'd0;
            end else begin
                if (push_en[g]) begin
                    mem[wp] <= push_data[g];
                    wp      <= ~wp;
                end
                if (pop_en[g]) begin
                    rp <= ~rp;
                end
                cnt <= cnt + 2'(push_en[g]) - 2'(pop_en[g]);
            end
        end

        assign pop_data[g]   = mem[rp];
        assign item_count[g] = cnt;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic exp_grant(input int inst, input int idx, input logic [3:0] d);
        grant_q.push_back('{inst: inst, idx: idx, data: d});
    endtask

    task automatic exp_data(input int inst, input logic [3:0] d);
        data_q.push_back('{inst: inst, data: d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every push and pop handshake against the queues.
    always @(negedge clk) begin
        grant_t ge;
        beat_t  be;
        logic   exp_pop;
        for (int g = 0; g < NI; g++) begin
            if (push_en[g] || (req_ready[g] != 4'b0)) begin
                if (grant_q.size() == 0) begin
                    fail_now($sformatf("unexpected_grant inst=%0d ready=%b", g, req_ready[g]));
                end else begin
                    ge = grant_q.pop_front();
                    check("grant_inst", g, ge.inst);
                    check("req_ready", {28'b0, req_ready[g]}, {28'b0, 4'b0001 << ge.idx});
                    check("push_enable", {31'b0, push_en[g]}, 32'd1);
                    check("push_data", {28'b0, push_data[g]}, {28'b0, ge.data});
                end
            end
            exp_pop = (item_count[g] != 2'd0) && out_ready[g] && !rst;
            if (exp_pop || pop_en[g]) begin
                check("pop_enable", {31'b0, pop_en[g]}, {31'b0, exp_pop});
                if (exp_pop) begin
                    if (data_q.size() == 0) begin
                        fail_now($sformatf("unexpected_pop inst=%0d data=%0h", g, out_data[g]));
                    end else begin
                        be = data_q.pop_front();
                        check("pop_inst", g, be.inst);
                        check("out_valid", {31'b0, out_valid[g]}, 32'd1);
                        check("out_data", {28'b0, out_data[g]}, {28'b0, be.data});
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            req_valid[g] = 4'b0;
            req_data[g]  = 16'h0;
            out_ready[g] = 1'b0;
        end

        // ---- Reset with all producers valid, then round robin (BURST=1) ----
        req_valid[0] = 4'b1111;
        req_data[0]  = 16'h4321;
        out_ready[0] = 1'b1;
        exp_grant(0, 0, 4'h1); exp_grant(0, 1, 4'h2); exp_grant(0, 2, 4'h3);
        exp_grant(0, 3, 4'h4); exp_grant(0, 0, 4'h1);
        exp_data(0, 4'h1); exp_data(0, 4'h2); exp_data(0, 4'h3);
        exp_data(0, 4'h4); exp_data(0, 4'h1);
        repeat (2) begin
            @(negedge clk);
            check("rst_req_ready", {28'b0, req_ready[0]}, 32'd0);
            check("rst_push_en", {31'b0, push_en[0]}, 32'd0);
            check("rst_locked", {31'b0, locked[0]}, 32'd0);
            check("rst_out_valid", {31'b0, out_valid[0]}, 32'd0);
        end
        step();
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        req_valid[0] = 4'b0;
        repeat (3) step();

        // ---- Burst of 2 between req0 and req2 ----
        req_valid[1] = 4'b0101;
        req_data[1]  = 16'h0705;
        out_ready[1] = 1'b1;
        exp_grant(1, 0, 4'h5); exp_grant(1, 0, 4'h5); exp_grant(1, 2, 4'h7);
        exp_grant(1, 2, 4'h7); exp_grant(1, 0, 4'h5); exp_grant(1, 0, 4'h5);
        exp_data(1, 4'h5); exp_data(1, 4'h5); exp_data(1, 4'h7);
        exp_data(1, 4'h7); exp_data(1, 4'h5); exp_data(1, 4'h5);
        @(posedge clk); @(negedge clk);
        check("burst_locked_a", {31'b0, locked[1]}, 32'd1);
        check("burst_owner_a", {30'b0, lock_owner[1]}, 32'd0);
        @(posedge clk); @(negedge clk);
        check("burst_unlocked_a", {31'b0, locked[1]}, 32'd0);
        @(posedge clk); @(negedge clk);
        check("burst_locked_b", {31'b0, locked[1]}, 32'd1);
        check("burst_owner_b", {30'b0, lock_owner[1]}, 32'd2);
        @(posedge clk); @(negedge clk);
        check("burst_unlocked_b", {31'b0, locked[1]}, 32'd0);
        @(posedge clk);
        step();
        req_valid[1] = 4'b0;
        repeat (3) step();

        // ---- Full stall on instance 0 ----
        out_ready[0] = 1'b0;
        req_valid[0] = 4'b0010;
        req_data[0]  = 16'h00A0;
        exp_grant(0, 1, 4'hA); exp_grant(0, 1, 4'hB); exp_grant(0, 1, 4'hC);
        exp_data(0, 4'hA); exp_data(0, 4'hB); exp_data(0, 4'hC);
        step();
        req_data[0] = 16'h00B0;
        step();
        req_data[0] = 16'h00C0;
        @(negedge clk);
        check("full_count", {30'b0, item_count[0]}, 32'd2);
        check("full_flag", {31'b0, full[0]}, 32'd1);
        check("full_empty", {31'b0, empty[0]}, 32'd0);
        check("full_req_ready", {28'b0, req_ready[0]}, 32'd0);
        check("full_push_en", {31'b0, push_en[0]}, 32'd0);
        step();
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("full_pop_no_push", {28'b0, req_ready[0]}, 32'd0);
        step();
        @(negedge clk);
        check("after_pop_grant", {28'b0, req_ready[0]}, 32'b0010);
        step();
        req_valid[0] = 4'b0;
        repeat (3) step();

        // ---- Owner drop (BURST=4) ----
        out_ready[2] = 1'b1;
        req_valid[2] = 4'b1000;
        req_data[2]  = 16'h3000;
        exp_grant(2, 3, 4'h3); exp_grant(2, 1, 4'h9);
        exp_data(2, 4'h3); exp_data(2, 4'h9);
        step();
        req_valid[2] = 4'b0010;
        req_data[2]  = 16'h0090;
        @(negedge clk);
        check("drop_same_cycle", {28'b0, req_ready[2]}, 32'b0010);
        check("drop_old_owner", {30'b0, lock_owner[2]}, 32'd3);
        step();
        req_valid[2] = 4'b0;
        @(negedge clk);
        check("drop_new_locked", {31'b0, locked[2]}, 32'd1);
        check("drop_new_owner", {30'b0, lock_owner[2]}, 32'd1);
        step();
        @(negedge clk);
        check("drop_release", {31'b0, locked[2]}, 32'd0);
        repeat (2) step();

        // ---- Reset mid-lock (BURST=4) ----
        out_ready[2] = 1'b0;
        req_valid[2] = 4'b0100;
        req_data[2]  = 16'h0600;
        exp_grant(2, 2, 4'h6); exp_grant(2, 2, 4'h6); exp_grant(2, 0, 4'h1);
        exp_data(2, 4'h1);
        step();
        @(posedge clk); @(negedge clk);
        check("mid_locked", {31'b0, locked[2]}, 32'd1);
        check("mid_owner", {30'b0, lock_owner[2]}, 32'd2);
        check("mid_count", {30'b0, item_count[2]}, 32'd2);
        step();
        rst          = 1'b1;
        req_valid[2] = 4'b0101;
        req_data[2]  = 16'h0601;
        @(negedge clk);
        check("mid_rst_ready", {28'b0, req_ready[2]}, 32'd0);
        check("mid_rst_locked", {31'b0, locked[2]}, 32'd0);
        check("mid_rst_owner", {30'b0, lock_owner[2]}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_locked", {31'b0, locked[2]}, 32'd0);
        check("post_rst_count", {30'b0, item_count[2]}, 32'd0);
        check("post_rst_grant", {28'b0, req_ready[2]}, 32'b0001);
        step();
        req_valid[2] = 4'b0;
        out_ready[2] = 1'b1;
        repeat (4) step();

        check("grant_q_drained", grant_q.size(), 32'd0);
        check("data_q_drained", data_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_push_arbiter

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin controller that shares one `fifo` instance between `N_REQ` producers and exposes the FIFO read side as a valid/ready stream. The `fifo` itself performs no overflow or underflow protection, so this block drives its `push_enable`/`pop_enable` only when its `item_count` allows. An optional burst lock lets one producer own the FIFO for up to `BURST` consecutive beats. It sits directly beside the `fifo` in any multi-source queueing path.

## Interface
- `N_REQ`, 4: number of producers, ≥2.
- `WIDTH`, 4: data width; must match the `fifo`.
- `DEPTH`, 2: FIFO depth; must match the `fifo`; power of two.
- `BURST`, 1: maximum consecutive beats per grant, ≥1.
- Local `CW = $clog2(DEPTH)+1`; local `IW = $clog2(N_REQ)`.

- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset. The top level drives the `fifo` with `rst_n = ~rst`.
- `req_valid` in N_REQ: producer i has data.
- `req_data` in N_REQ*WIDTH: producer i data, at bits [i*WIDTH +: WIDTH].
- `req_ready` out N_REQ: one-hot or zero. Producer i's beat is accepted this cycle.
- `fifo_push_enable` out 1: to `fifo.push_enable`.
- `fifo_push_data` out WIDTH: to `fifo.push_data`.
- `fifo_pop_enable` out 1: to `fifo.pop_enable`.
- `fifo_pop_data` in WIDTH: from `fifo.pop_data`.
- `fifo_item_count` in CW: from `fifo.item_count`.
- `out_valid` out 1: FIFO non-empty.
- `out_data` out WIDTH: equals `fifo_pop_data`.
- `out_ready` in 1: consumer accepts.
- `full` out 1: `fifo_item_count == DEPTH`.
- `empty` out 1: `fifo_item_count == 0`.
- `lock_owner` out IW: current burst owner. Valid while `locked`.
- `locked` out 1: the FSM is in LOCKED.

## Operation
- **Registered state:** `state` {IDLE, LOCKED}, `owner`, `beat_cnt` (width `$clog2(BURST+1)`), `rr_ptr`. All reset to IDLE/0.
- **Winner selection** is combinational:
  - In LOCKED, if `req_valid[owner]` is set, the winner is `owner`.
  - Otherwise the winner is the first valid index searching upward from `rr_ptr`, wrapping modulo N_REQ.
  - An owner that drops `req_valid` in LOCKED releases the lock in that same cycle. The cycle is then arbitrated as in IDLE.
- **Push:** `push = winner_found & !full & !rst`.
  - `fifo_push_enable = push`.
  - `fifo_push_data = req_data[winner]`.
  - `req_ready[winner] = push`.
  - There is no push-through when full, even with a simultaneous pop.
- **Pop:**
  - `out_valid = !empty`.
  - `fifo_pop_enable = out_valid & out_ready & !rst`.
- **FSM, on a push by a new winner** (not a continuing lock):
  - `rr_ptr <= (winner+1) mod N_REQ`.
  - If BURST==1, stay IDLE.
  - Otherwise: LOCKED, `owner <= winner`, `beat_cnt <= 1`.
- **FSM, on a push by the locked owner:**
  - `beat_cnt+1`.
  - If it reaches BURST, go to IDLE and set `beat_cnt <= 0`.
- **LOCKED, owner valid, `full`:** stall. State, owner and `beat_cnt` hold, and no other producer is granted.
- **LOCKED, owner invalid, no push:** go to IDLE.
- **Simultaneous push and pop:** both are issued. The `fifo` count holds.

## Timing
- Grant has zero latency: `req_ready` is combinational from `req_valid`, state and `fifo_item_count`.
- A pushed word appears on `out_data`/`out_valid` one cycle after the accepting edge.
- `full`/`empty` reflect `fifo_item_count`, which updates one edge after a push or pop.
- **While `rst` is high:** all enables, `req_ready`, `locked` and `lock_owner` are 0. `out_valid` follows the `fifo` count, which is 0 since the `fifo` is held in reset.
- **Reset mid-burst:** the lock is dropped at that edge. The first grant after reset goes to the lowest valid index.

## Structure
- **Package `fifo_ctrl_pkg`:** `state_t` enum (IDLE, LOCKED).
- **Sub-module `rr_pick`:** parameter N; inputs `valid[N]` and `start[$clog2(N)]`; outputs `found` and `idx`. Pure combinational rotate-priority search.
- **Top:** FSM, counters and muxing only.

## Test plan
- **Reset:** all `req_valid=1111`, `rst` high for 2 cycles → `req_ready=0000` and `fifo_push_enable=0` during reset. First grant after release goes to req0.
- **Round robin:** BURST=1, `out_ready=1`, all valid with data 1,2,3,4 → grants 0,1,2,3,0. `out_data` sequence 1,2,3,4,1, each one cycle after push.
- **Burst:** BURST=2, req0 and req2 valid, `out_ready=1` → grant order 0,0,2,2,0,0. `locked=1` with `lock_owner` 0 then 2.
- **Full stall:** `out_ready=0`, req1 pushes 0xA, 0xB → `item_count=2`, `full=1`, `req_ready=0000`. Raise `out_ready` → pop 0xA; the next cycle accepts the following req1 word.
- **Owner drop:** BURST=4, req3 pushes one beat then deasserts while req1 is valid → req1 is granted in the same cycle req3 drops, and the lock moves to 1.
- **Reset mid-lock:** BURST=4, req2 locked after 2 beats, assert `rst` one cycle → `locked=0`, `item_count=0`. req0 and req2 valid → req0 granted first.
